// File: rtl/axi_id_remap_table.sv
// AXI ID remapper: compresses wide upstream IDs onto a small table of slots and
// restores the original ID on the response path, keeping per-ID ordering.
module axi_id_remap_table #(
  parameter int unsigned ID_IN_W  = 8,
  parameter int unsigned ID_OUT_W = 4,
  parameter int unsigned SLOTS    = 16,
  parameter int unsigned MAX_TXN  = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [ID_IN_W-1:0]           req_id_i,
  output logic                         fwd_valid_o,
  input  logic                         fwd_ready_i,
  output logic [ID_OUT_W-1:0]          fwd_id_o,
  input  logic                         rsp_valid_i,
  output logic                         rsp_ready_o,
  input  logic [ID_OUT_W-1:0]          rsp_id_i,
  input  logic                         rsp_last_i,
  output logic                         bwd_valid_o,
  input  logic                         bwd_ready_i,
  output logic [ID_IN_W-1:0]           bwd_id_o,
  output logic [$clog2(SLOTS+1)-1:0]   free_slots_o,
  output logic                         err_o
);

  localparam int unsigned CNT_W  = $clog2(MAX_TXN + 1);
  localparam int unsigned FREE_W = $clog2(SLOTS + 1);

  logic [SLOTS-1:0]    vld_q, vld_d;
  logic [ID_IN_W-1:0]  in_id_q [SLOTS];
  logic [ID_IN_W-1:0]  in_id_d [SLOTS];
  logic [CNT_W-1:0]    cnt_q   [SLOTS];
  logic [CNT_W-1:0]    cnt_d   [SLOTS];
  logic                lock_q, lock_d;
  logic [ID_OUT_W-1:0] lock_idx_q, lock_idx_d;
  logic                err_q, err_d;
  logic [FREE_W-1:0]   free_q, free_d;

  logic                hit, has_free, sel_full, stall;
  logic [ID_OUT_W-1:0] hit_idx, free_idx, sel_idx;
  logic                accept, release_beat;
  logic                rsp_hit;
  logic [ID_IN_W-1:0]  rsp_in_id;
  logic [SLOTS-1:0]    inc_slot, dec_slot;

  // Lookup: lowest matching valid entry first, otherwise lowest free entry.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (!hit && vld_q[i] && (in_id_q[i] == req_id_i)) begin
        hit     = 1'b1;
        hit_idx = ID_OUT_W'(i);
      end
      if (!has_free && !vld_q[i]) begin
        has_free = 1'b1;
        free_idx = ID_OUT_W'(i);
      end
    end
  end

  // A pending (locked) request keeps its slot so fwd_id_o is stable under backpressure.
  always_comb begin
    if (lock_q) begin
      sel_idx = lock_idx_q;
    end else if (hit) begin
      sel_idx = hit_idx;
    end else begin
      sel_idx = free_idx;
    end
    sel_full = 1'b0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (sel_idx == ID_OUT_W'(i)) begin
        sel_full = vld_q[i] && (cnt_q[i] == CNT_W'(MAX_TXN));
      end
    end
    stall = sel_full || (!lock_q && !hit && !has_free);
  end

  assign fwd_valid_o = req_valid_i & ~stall;
  assign req_ready_o = fwd_ready_i & ~stall;
  assign fwd_id_o    = sel_idx;
  assign accept      = req_valid_i & req_ready_o;

  // Response lookup; out-of-range IDs resolve to an invalid entry.
  always_comb begin
    rsp_hit   = 1'b0;
    rsp_in_id = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (rsp_id_i == ID_OUT_W'(i)) begin
        rsp_hit   = vld_q[i];
        rsp_in_id = in_id_q[i];
      end
    end
  end

  assign bwd_id_o     = rsp_in_id;
  assign bwd_valid_o  = rsp_valid_i & rsp_hit;
  assign rsp_ready_o  = rsp_hit ? bwd_ready_i : 1'b1;
  assign release_beat = rsp_valid_i & rsp_hit & bwd_ready_i & rsp_last_i;
  assign err_o        = err_q;
  assign free_slots_o = free_q;

  always_comb begin
    inc_slot = '0;
    dec_slot = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      inc_slot[i] = accept && (sel_idx == ID_OUT_W'(i));
      dec_slot[i] = release_beat && (rsp_id_i == ID_OUT_W'(i));
    end
  end

  // Table next state; simultaneous accept and release on one slot cancel out.
  always_comb begin
    vld_d   = vld_q;
    in_id_d = in_id_q;
    cnt_d   = cnt_q;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (inc_slot[i] && !dec_slot[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_slot[i] && !inc_slot[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      if (inc_slot[i]) begin
        vld_d[i]   = 1'b1;
        in_id_d[i] = req_id_i;
      end else if (dec_slot[i] && (cnt_q[i] == CNT_W'(1))) begin
        vld_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    free_d = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (!vld_d[i]) begin
        free_d = free_d + FREE_W'(1);
      end
    end
  end

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (!req_valid_i || accept) begin
      lock_d = 1'b0;
    end else if (fwd_valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = sel_idx;
    end
  end

  assign err_d = err_q | (rsp_valid_i & ~rsp_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
      free_q     <= FREE_W'(SLOTS);
      for (int unsigned i = 0; i < SLOTS; i++) begin
        in_id_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      vld_q      <= vld_d;
      in_id_q    <= in_id_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
      free_q     <= free_d;
    end
  end

endmodule

// File: tb/tb_axi_id_remap_table.sv
// Bench for axi_id_remap_table: directed scenarios then randomized traffic,
// all checked against a count-per-slot reference model.
module tb_axi_id_remap_table;

  localparam int ID_IN_W  = 8;
  localparam int ID_OUT_W = 4;
  localparam int SLOTS    = 16;
  localparam int MAX_TXN  = 7;
  localparam int FREE_W   = $clog2(SLOTS + 1);

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [ID_IN_W-1:0]  req_id = '0;
  logic                fwd_valid;
  logic                fwd_ready = 1'b0;
  logic [ID_OUT_W-1:0] fwd_id;
  logic                rsp_valid = 1'b0;
  logic                rsp_ready;
  logic [ID_OUT_W-1:0] rsp_id = '0;
  logic                rsp_last = 1'b0;
  logic                bwd_valid;
  logic                bwd_ready = 1'b0;
  logic [ID_IN_W-1:0]  bwd_id;
  logic [FREE_W-1:0]   free_slots;
  logic                err;

  always #5 clk = ~clk;

  axi_id_remap_table #(
    .ID_IN_W (ID_IN_W),
    .ID_OUT_W(ID_OUT_W),
    .SLOTS   (SLOTS),
    .MAX_TXN (MAX_TXN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_id_i    (req_id),
    .fwd_valid_o (fwd_valid),
    .fwd_ready_i (fwd_ready),
    .fwd_id_o    (fwd_id),
    .rsp_valid_i (rsp_valid),
    .rsp_ready_o (rsp_ready),
    .rsp_id_i    (rsp_id),
    .rsp_last_i  (rsp_last),
    .bwd_valid_o (bwd_valid),
    .bwd_ready_i (bwd_ready),
    .bwd_id_o    (bwd_id),
    .free_slots_o(free_slots),
    .err_o       (err)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: a slot is in use exactly when its outstanding count is non-zero.
  int m_cnt [SLOTS];
  int m_id  [SLOTS];
  bit m_lock;
  int m_lock_slot;
  bit m_err;
  bit chk_en = 1'b0;

  int e_sel;
  bit e_stall;
  bit e_rsp_hit;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int model_free();
    int n = 0;
    for (int i = 0; i < SLOTS; i++) if (m_cnt[i] == 0) n++;
    return n;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < SLOTS; i++) begin
      m_cnt[i] = 0;
      m_id[i]  = 0;
    end
    m_lock      = 1'b0;
    m_lock_slot = 0;
    m_err       = 1'b0;
  endfunction

  function automatic void model_lookup();
    e_sel   = -1;
    e_stall = 1'b0;
    if (m_lock) begin
      e_sel   = m_lock_slot;
      e_stall = (m_cnt[e_sel] == MAX_TXN);
    end else begin
      for (int i = 0; i < SLOTS; i++)
        if (e_sel < 0 && m_cnt[i] > 0 && m_id[i] == int'(req_id)) e_sel = i;
      if (e_sel >= 0) begin
        e_stall = (m_cnt[e_sel] == MAX_TXN);
      end else begin
        for (int i = 0; i < SLOTS; i++)
          if (e_sel < 0 && m_cnt[i] == 0) e_sel = i;
        if (e_sel < 0) begin
          e_stall = 1'b1;
          e_sel   = 0;
        end
      end
    end
    e_rsp_hit = (int'(rsp_id) < SLOTS) && (m_cnt[int'(rsp_id)] > 0);
  endfunction

  // Call at the negative edge with inputs already stable.
  task automatic advance();
    bit fv, acc, rel;
    model_lookup();
    fv = req_valid && !e_stall;
    if (chk_en) begin
      chk("fwd_valid", 32'(fwd_valid), 32'(fv));
      chk("req_ready", 32'(req_ready), 32'(fwd_ready && !e_stall));
      if (fv) chk("fwd_id", 32'(fwd_id), 32'(e_sel));
      chk("bwd_valid", 32'(bwd_valid), 32'(rsp_valid && e_rsp_hit));
      chk("rsp_ready", 32'(rsp_ready), 32'(e_rsp_hit ? bwd_ready : 1'b1));
      if (e_rsp_hit) chk("bwd_id", 32'(bwd_id), 32'(m_id[int'(rsp_id)]));
      chk("free_slots", 32'(free_slots), 32'(model_free()));
      chk("err", 32'(err), 32'(m_err));
    end
    @(posedge clk);
    acc = fv && fwd_ready;
    rel = rsp_valid && e_rsp_hit && bwd_ready && rsp_last;
    if (rst) begin
      model_reset();
    end else begin
      if (acc) begin
        m_cnt[e_sel]++;
        m_id[e_sel] = int'(req_id);
      end
      if (rel) m_cnt[int'(rsp_id)]--;
      if (rsp_valid && !e_rsp_hit) m_err = 1'b1;
      if (!req_valid || acc) m_lock = 1'b0;
      else if (fv) begin
        m_lock      = 1'b1;
        m_lock_slot = e_sel;
      end
    end
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    advance();
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    fwd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_last  = 1'b0;
    bwd_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic issue(input int id);
    req_valid = 1'b1;
    fwd_ready = 1'b1;
    req_id    = 8'(id);
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    bit hold;
    model_reset();
    do_reset();
    chk_en = 1'b1;

    // Reset state
    fwd_ready = 1'b1;
    @(negedge clk);
    chk("rst_free", 32'(free_slots), 32'(SLOTS));
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_bwd_valid", 32'(bwd_valid), 32'd0);
    advance();

    // First issue lands on slot 0 in the same cycle
    req_valid = 1'b1;
    req_id    = 8'h5A;
    @(negedge clk);
    chk("first_fwd_id", 32'(fwd_id), 32'd0);
    chk("first_fwd_valid", 32'(fwd_valid), 32'd1);
    advance();
    req_valid = 1'b0;
    @(negedge clk);
    chk("first_free", 32'(free_slots), 32'd15);
    advance();

    // Per-slot saturation: 6 more of 0x5A fill slot 0, the next stalls
    for (int k = 0; k < MAX_TXN - 1; k++) issue(8'h5A);
    req_valid = 1'b1;
    fwd_ready = 1'b1;
    req_id    = 8'h5A;
    @(negedge clk);
    chk("sat_stall", 32'(fwd_valid), 32'd0);
    advance();
    rsp_valid = 1'b1;
    rsp_id    = 4'd0;
    rsp_last  = 1'b1;
    bwd_ready = 1'b1;
    @(negedge clk);
    chk("sat_bwd_id", 32'(bwd_id), 32'h5A);
    chk("sat_still_stall", 32'(fwd_valid), 32'd0);
    advance();
    rsp_valid = 1'b0;
    @(negedge clk);
    chk("sat_resume_valid", 32'(fwd_valid), 32'd1);
    chk("sat_resume_id", 32'(fwd_id), 32'd0);
    advance();
    idle_inputs();
    step();

    // Table full: 16 distinct IDs, 17th stalls until a release
    do_reset();
    for (int k = 0; k < SLOTS; k++) begin
      req_valid = 1'b1;
      fwd_ready = 1'b1;
      req_id    = 8'(8'h80 + k);
      @(negedge clk);
      chk("fill_id", 32'(fwd_id), 32'(k));
      advance();
    end
    req_id = 8'h90;
    @(negedge clk);
    chk("full_free", 32'(free_slots), 32'd0);
    chk("full_stall", 32'(fwd_valid), 32'd0);
    advance();
    step();
    rsp_valid = 1'b1;
    rsp_id    = 4'd7;
    rsp_last  = 1'b1;
    bwd_ready = 1'b1;
    step();
    rsp_valid = 1'b0;
    @(negedge clk);
    chk("full_resume_id", 32'(fwd_id), 32'd7);
    chk("full_resume_valid", 32'(fwd_valid), 32'd1);
    advance();
    idle_inputs();
    step();

    // Lock: slot 2 held under backpressure while slot 1 frees up
    do_reset();
    issue(8'h10);
    issue(8'h11);
    req_valid = 1'b1;
    fwd_ready = 1'b0;
    req_id    = 8'h33;
    @(negedge clk);
    chk("lock_sel", 32'(fwd_id), 32'd2);
    advance();
    rsp_valid = 1'b1;
    rsp_id    = 4'd1;
    rsp_last  = 1'b1;
    bwd_ready = 1'b1;
    step();
    rsp_valid = 1'b0;
    @(negedge clk);
    chk("lock_hold", 32'(fwd_id), 32'd2);
    advance();
    fwd_ready = 1'b1;
    @(negedge clk);
    chk("lock_handshake", 32'(fwd_id), 32'd2);
    advance();
    idle_inputs();
    step();

    // Multi-beat response on slot 3
    do_reset();
    for (int k = 0; k < 4; k++) issue(8'h40 + k);
    rsp_valid = 1'b1;
    rsp_id    = 4'd3;
    bwd_ready = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      rsp_last = (b == 4);
      @(negedge clk);
      chk("beat_bwd_id", 32'(bwd_id), 32'h43);
      chk("beat_free", 32'(free_slots), 32'd12);
      advance();
    end
    rsp_valid = 1'b0;
    @(negedge clk);
    chk("beat_done_free", 32'(free_slots), 32'd13);
    advance();

    // Response to an invalid slot: dropped, sticky error
    rsp_valid = 1'b1;
    rsp_id    = 4'd9;
    rsp_last  = 1'b1;
    bwd_ready = 1'b0;
    @(negedge clk);
    chk("inv_rsp_ready", 32'(rsp_ready), 32'd1);
    chk("inv_bwd_valid", 32'(bwd_valid), 32'd0);
    advance();
    rsp_valid = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("inv_err_sticky", 32'(err), 32'd1);
    advance();
    do_reset();
    @(negedge clk);
    chk("inv_err_cleared", 32'(err), 32'd0);
    advance();

    // Randomized traffic; a locked request usually stays put as AXI requires
    for (int n = 0; n < 4000; n++) begin
      hold = m_lock && ($urandom_range(0, 9) != 0);
      if (!hold) begin
        req_valid = ($urandom_range(0, 2) != 0);
        req_id    = 8'(8'hA0 + $urandom_range(0, 19));
      end
      fwd_ready = ($urandom_range(0, 3) != 0);
      rsp_valid = ($urandom_range(0, 1) != 0);
      rsp_id    = 4'($urandom_range(0, SLOTS - 1));
      rsp_last  = ($urandom_range(0, 2) != 0);
      bwd_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
